// File: rtl/rat_input_pkg.sv
// Shared types and defaults for the RAT input-conditioning blocks.
// Holds the button FSM state encoding and default timing parameters.
package rat_input_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    PRESSED,
    DB_RELEASE
  } btn_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int PULSE_CYCLES_DEF    = 2;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous level inputs.
// Used for the push-button here and for the SWITCHES inputs.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_intr_gen.sv
// Debounced button level plus one-shot MCU interrupt per press.
// Define BTN_PRESS_COUNT_EN to add the 8-bit PRESS_COUNT output.
module btn_intr_gen
  import rat_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int PULSE_CYCLES    = PULSE_CYCLES_DEF
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BTN_IN,
`ifdef BTN_PRESS_COUNT_EN
  output logic [7:0] PRESS_COUNT,
`endif
  output logic       DB_LEVEL,
  output logic       INTR
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PLS_LOAD = PW'(PULSE_CYCLES);

  if (DEBOUNCE_CYCLES < 2 || PULSE_CYCLES < 1 ||
      PULSE_CYCLES > DEBOUNCE_CYCLES) begin : g_param_chk
    $fatal(1, "btn_intr_gen: illegal DEBOUNCE_CYCLES/PULSE_CYCLES");
  end

  logic          s;
  btn_state_t    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [PW-1:0] pcnt;
  logic          fire;

  sync_2ff #(.WIDTH(1)) u_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .d     (BTN_IN),
    .q     (s)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    fire    = 1'b0;
    unique case (state)
      IDLE: begin
        if (s) begin
          state_d = DB_PRESS;
          cnt_d   = '0;
        end
      end
      DB_PRESS: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == CNT_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
          fire    = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = DB_RELEASE;
          cnt_d   = '0;
        end
      end
      DB_RELEASE: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      cnt      <= '0;
      DB_LEVEL <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      DB_LEVEL <= (state_d == PRESSED) ||
                  (state_d == DB_RELEASE);
    end
  end

  // Only a fresh press loads the pulse; release bounce cannot retrigger.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pcnt <= '0;
      INTR <= 1'b0;
    end else if (fire) begin
      pcnt <= PLS_LOAD;
      INTR <= 1'b1;
    end else if (pcnt != '0) begin
      pcnt <= pcnt - PW'(1);
      INTR <= (pcnt != PW'(1));
    end
  end

`ifdef BTN_PRESS_COUNT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PRESS_COUNT <= '0;
    end else if (fire) begin
      PRESS_COUNT <= PRESS_COUNT + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_btn_intr_gen.sv
// Self-checking bench for btn_intr_gen (DEBOUNCE_CYCLES=4, PULSE_CYCLES=2).
// Expected outputs come from a run-length reference model via a queue.
module tb_btn_intr_gen;

  localparam int D = 4;
  localparam int P = 2;

  logic CLK;
  logic RST_N;
  logic BTN_IN;
  logic DB_LEVEL;
  logic INTR;
`ifdef BTN_PRESS_COUNT_EN
  logic [7:0] PRESS_COUNT;
`endif

  btn_intr_gen #(
    .DEBOUNCE_CYCLES (D),
    .PULSE_CYCLES    (P)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .BTN_IN      (BTN_IN),
`ifdef BTN_PRESS_COUNT_EN
    .PRESS_COUNT (PRESS_COUNT),
`endif
    .DB_LEVEL    (DB_LEVEL),
    .INTR        (INTR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic db;
    logic intr;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int passes = 0;
  int rises  = 0;
  logic prev_intr = 1'b0;

  // Reference model: synchroniser delay line plus run-length debounce.
  logic m_s1 = 1'b0;
  logic m_s2 = 1'b0;
  logic m_lvl = 1'b0;
  logic m_intr = 1'b0;
  int   m_run = 0;
  int   m_rem = 0;
  int   m_presses = 0;

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %b expected %b", tag, got, exp);
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_clear();
    m_s1   = 1'b0;
    m_s2   = 1'b0;
    m_lvl  = 1'b0;
    m_intr = 1'b0;
    m_run  = 0;
    m_rem  = 0;
    prev_intr = 1'b0;
  endtask

  task automatic model_step(input logic b);
    logic x;
    logic rose;
    x    = m_s2;
    m_s2 = m_s1;
    m_s1 = b;
    rose = 1'b0;
    if (x != m_lvl) begin
      m_run++;
      if (m_run == D + 1) begin
        m_lvl = x;
        m_run = 0;
        rose  = x;
      end
    end else begin
      m_run = 0;
    end
    if (rose) begin
      m_rem = P;
      m_presses++;
    end else if (m_rem > 0) begin
      m_rem--;
    end
    m_intr = (m_rem > 0);
  endtask

  task automatic tick(input logic b, input string tag);
    exp_t e;
    BTN_IN = b;
    model_step(b);
    e.db   = m_lvl;
    e.intr = m_intr;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      chk(tag, 1'b1, 1'b0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_db"}, DB_LEVEL, e.db);
      chk({tag, "_intr"}, INTR, e.intr);
    end
    if (INTR && !prev_intr) rises++;
    prev_intr = INTR;
  endtask

  task automatic do_reset(input string tag);
    RST_N = 1'b0;
    #1;
    chk({tag, "_rst_db"}, DB_LEVEL, 1'b0);
    chk({tag, "_rst_intr"}, INTR, 1'b0);
    model_clear();
    sb.delete();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit found;

    RST_N  = 1'b0;
    BTN_IN = 1'b0;
    #3;
    chk("reset_db", DB_LEVEL, 1'b0);
    chk("reset_intr", INTR, 1'b0);
`ifdef BTN_PRESS_COUNT_EN
    chk_int("reset_count", int'(PRESS_COUNT), 0);
`endif
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    repeat (4) tick(1'b0, "idle");

    // Clean press: rise D+2 edges after first sampling edge.
    n = 0;
    found = 0;
    rises = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1'b1, "clean");
      n++;
      if (INTR) found = 1;
    end
    chk("clean_seen", found, 1'b1);
    chk_int("clean_latency", n - 1, D + 2);
    chk("clean_db_rise", DB_LEVEL, 1'b1);
    tick(1'b1, "clean_hold");
    chk("clean_intr_2nd", INTR, 1'b1);
    tick(1'b1, "clean_hold");
    chk("clean_intr_fall", INTR, 1'b0);
    chk("clean_db_held", DB_LEVEL, 1'b1);
    repeat (6) tick(1'b1, "clean_hold");
    repeat (10) tick(1'b0, "clean_rel");
    chk("clean_db_fall", DB_LEVEL, 1'b0);
    chk_int("clean_one_intr", rises, 1);

    // Press bounce.
    rises = 0;
    tick(1'b1, "pb");
    tick(1'b0, "pb");
    tick(1'b1, "pb");
    tick(1'b0, "pb");
    repeat (12) tick(1'b1, "pb_hold");
    chk_int("pb_one_intr", rises, 1);
    chk("pb_db", DB_LEVEL, 1'b1);

    // Release bounce while pressed.
    rises = 0;
    tick(1'b0, "rb");
    tick(1'b0, "rb");
    repeat (10) tick(1'b1, "rb_hold");
    chk("rb_db_stays", DB_LEVEL, 1'b1);
    chk_int("rb_no_intr", rises, 0);
    repeat (10) tick(1'b0, "rb_rel");
    chk("rb_db_fall", DB_LEVEL, 1'b0);

    // Short glitch from idle.
    rises = 0;
    repeat (3) tick(1'b1, "glitch");
    repeat (10) tick(1'b0, "glitch_low");
    chk_int("glitch_no_intr", rises, 0);
    chk("glitch_db", DB_LEVEL, 1'b0);

    // Reset mid-pulse, button held through reset.
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1'b1, "mid");
      if (INTR) found = 1;
    end
    chk("mid_seen", found, 1'b1);
    tick(1'b1, "mid_pulse");
    do_reset("mid");
    n = 0;
    found = 0;
    rises = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1'b1, "mid_again");
      n++;
      if (INTR) found = 1;
    end
    chk("mid_reintr", found, 1'b1);
    chk_int("mid_latency", n - 1, D + 2);
    repeat (4) tick(1'b1, "mid_hold");
    repeat (10) tick(1'b0, "mid_rel");
    chk_int("mid_one_intr", rises, 1);

`ifdef BTN_PRESS_COUNT_EN
    do_reset("cnt");
    m_presses = 0;
    repeat (257) begin
      repeat (8) tick(1'b1, "cnt_p");
      repeat (8) tick(1'b0, "cnt_r");
    end
    chk_int("cnt_model", int'(PRESS_COUNT), m_presses % 256);
    chk_int("cnt_wrap", int'(PRESS_COUNT), 1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
